// File: rtl/mips_pkg.sv
// mips_pkg: shared types and widths for the data-memory responder.
package mips_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core <-> data-memory request/response bundle.
interface dmem_responder_if;
  import mips_pkg::*;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              addr_err;
  modport master (output mem_read, mem_write, addr, wdata, input rdata, stall, done, addr_err);
  modport slave (input mem_read, mem_write, addr, wdata, output rdata, stall, done, addr_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and asynchronous read.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder that stalls the core until done.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic              rd_q, rd_d, wr_q, wr_d, done_q, done_d, err_q, err_d;
  logic              req, idle, go_done, err, we, rd, wr;
  logic [DATA_W-1:0] a, d, mem_rdata;
  // In IDLE the live inputs are the request being captured; afterwards only the held copy counts.
  always_comb begin
    req     = bus.mem_read | bus.mem_write;
    idle    = state_q == IDLE;
    a       = idle ? bus.addr : addr_q;
    d       = idle ? bus.wdata : wdata_q;
    rd      = idle ? bus.mem_read : rd_q;
    wr      = idle ? bus.mem_write : wr_q;
    err     = (a[1:0] != 2'b00) || (|a[DATA_W-1:AW+2]) || (rd && wr);
    go_done = idle ? (req && LATENCY == 1) : (state_q == WAIT && cnt_q == CW'(1));
    we      = go_done && wr && !err && !rst;
    state_d = go_done ? DONE : idle ? (req ? WAIT : IDLE) : (state_q == WAIT ? WAIT : IDLE);
    cnt_d   = idle ? CW'(LATENCY - 1) : cnt_q - CW'(1);
    addr_d  = a;
    wdata_d = d;
    rd_d    = rd;
    wr_d    = wr;
    rdata_d = go_done ? (err ? '0 : mem_rdata) : rdata_q;
    done_d  = go_done;
    err_d   = go_done && err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .we   (we),
    .idx  (a[AW+1:2]),
    .wdata(d),
    .rdata(mem_rdata)
  );
  assign bus.stall    = state_q == WAIT || (idle && req);
  assign bus.done     = done_q;
  assign bus.addr_err = err_q;
  assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a LATENCY=2 and a LATENCY=1 responder.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  dmem_responder_if a_if ();
  dmem_responder_if b_if ();
  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(a_if));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(b_if));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op2(input logic rd, input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                     input logic e, input logic ck, input logic [31:0] exp, input string tag);
    a_if.mem_read = rd; a_if.mem_write = wr; a_if.addr = ad; a_if.wdata = wd;
    #1;
    chk({tag, ".stall_t0"}, a_if.stall, 1);
    @(posedge clk); #1;
    chk({tag, ".stall_t1"}, a_if.stall, 1);
    chk({tag, ".done_t1"}, a_if.done, 0);
    @(posedge clk); #1;
    chk({tag, ".done"}, a_if.done, 1);
    chk({tag, ".stall_done"}, a_if.stall, 0);
    chk({tag, ".err"}, a_if.addr_err, e);
    if (e || ck) chk({tag, ".rdata"}, a_if.rdata, e ? 32'h0 : exp);
    a_if.mem_read = 1'b0; a_if.mem_write = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".done_after"}, a_if.done, 0);
  endtask
  task automatic op1(input logic rd, input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                     input logic ck, input logic [31:0] exp, input string tag);
    b_if.mem_read = rd; b_if.mem_write = wr; b_if.addr = ad; b_if.wdata = wd;
    #1;
    chk({tag, ".stall_t0"}, b_if.stall, 1);
    @(posedge clk); #1;
    chk({tag, ".done"}, b_if.done, 1);
    chk({tag, ".stall_done"}, b_if.stall, 0);
    if (ck) chk({tag, ".rdata"}, b_if.rdata, exp);
    b_if.mem_read = 1'b0; b_if.mem_write = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    a_if.mem_read = 0; a_if.mem_write = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.mem_read = 0; b_if.mem_write = 0; b_if.addr = 0; b_if.wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", a_if.stall, 0);
    chk("rst.done", a_if.done, 0);
    chk("rst.err", a_if.addr_err, 0);
    chk("rst.rdata", a_if.rdata, 0);
    chk("rst.l1_done", b_if.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    // LATENCY=1: preload, then back-to-back loads with done two cycles apart
    op1(0, 1, 32'h0, 32'h12345678, 0, 0, "l1_st0");
    op1(0, 1, 32'h4, 32'h9ABCDEF0, 0, 0, "l1_st4");
    b_if.mem_read = 1; b_if.addr = 32'h0;
    #1;
    chk("l1_b2b.stall_a", b_if.stall, 1);
    chk("l1_b2b.done_a0", b_if.done, 0);
    @(posedge clk); #1;
    chk("l1_b2b.done_a", b_if.done, 1);
    chk("l1_b2b.stall_da", b_if.stall, 0);
    chk("l1_b2b.rdata_a", b_if.rdata, 32'h12345678);
    b_if.addr = 32'h4;
    @(posedge clk); #1;
    chk("l1_b2b.stall_b", b_if.stall, 1);
    chk("l1_b2b.done_gap", b_if.done, 0);
    @(posedge clk); #1;
    chk("l1_b2b.done_b", b_if.done, 1);
    chk("l1_b2b.rdata_b", b_if.rdata, 32'h9ABCDEF0);
    b_if.mem_read = 0;
    @(posedge clk); #1;
    chk("l1_b2b.done_end", b_if.done, 0);
    // LATENCY=2: store/load, rejected accesses, aliasing targets stay intact
    op2(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, "st10");
    op2(1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, "ld10");
    op2(0, 1, 32'h0, 32'hA5A5A5A5, 0, 0, 0, "st00");
    op2(0, 1, 32'h13, 32'h11111111, 1, 0, 0, "st13_misal");
    op2(0, 1, 32'h400, 32'h22222222, 1, 0, 0, "st400_range");
    op2(1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, "ld10_after_err");
    op2(1, 0, 32'h0, 32'h0, 0, 1, 32'hA5A5A5A5, "ld00_after_err");
    op2(1, 1, 32'h10, 32'h33333333, 1, 0, 0, "rdwr_both");
    op2(1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, "ld10_after_both");
    // reset while in WAIT discards the pending store
    a_if.mem_write = 1; a_if.addr = 32'h10; a_if.wdata = 32'h44444444;
    #1;
    chk("rstwait.stall_t0", a_if.stall, 1);
    @(posedge clk); #1;
    chk("rstwait.stall_t1", a_if.stall, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    a_if.mem_write = 0; rst = 1'b0;
    #1;
    chk("rstwait.stall", a_if.stall, 0);
    chk("rstwait.done", a_if.done, 0);
    chk("rstwait.rdata", a_if.rdata, 0);
    @(posedge clk); #1;
    op2(1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, "ld10_after_rst");
    // address change during WAIT is ignored
    a_if.mem_read = 1; a_if.addr = 32'h0;
    #1;
    chk("chg.stall_t0", a_if.stall, 1);
    @(posedge clk); #1;
    a_if.addr = 32'h10;
    #1;
    chk("chg.stall_t1", a_if.stall, 1);
    @(posedge clk); #1;
    chk("chg.done", a_if.done, 1);
    chk("chg.err", a_if.addr_err, 0);
    chk("chg.rdata", a_if.rdata, 32'hA5A5A5A5);
    a_if.mem_read = 0;
    @(posedge clk); #1;
    chk("chg.rdata_hold", a_if.rdata, 32'hA5A5A5A5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. Accepts the core's `MemRead`/`MemWrite` request, address and store data, and serves it from an internal word array after a fixed, parameterised access latency. While the access is in progress it holds the core with `stall`. It sits between the core's ALU-result/ReadData2 outputs and the MemtoReg mux, as a variable-latency replacement for the zero-wait data memory.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2: cycles from request acceptance to completion; must be at least 1.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset is synchronous and active-high.
- `mem_read`, in, 1: core load request.
- `mem_write`, in, 1: core store request.
- `addr`, in, 32: byte address (ALU result).
- `wdata`, in, 32: store data.
- `rdata`, out, 32: load data; registered.
- `stall`, out, 1: core must hold PC and request stable while high.
- `done`, out, 1: one-cycle pulse; the request completes this cycle.
- `addr_err`, out, 1: one-cycle pulse coincident with `done`; the access was rejected.

## Operation
- A request is present (`req`) when `mem_read | mem_write`.
- Reset values: state IDLE, `rdata`=0, `done`=0, `addr_err`=0, counter 0. Array contents are not cleared.
- The FSM states are IDLE, WAIT and DONE.
- **IDLE**
  - `stall` = `req` (combinational).
  - On `req`, capture `addr`, `wdata` and the operation into holding registers, and load counter with `LATENCY-1`.
  - Go to DONE if `LATENCY`==1, otherwise go to WAIT.
- **WAIT**
  - `stall`=1.
  - Decrement the counter each cycle.
  - When the counter equals 1, go to DONE on the next edge.
- **DONE**
  - `stall`=0, `done`=1.
  - The store is committed to the array on the edge entering DONE. `rdata` is loaded on that same edge from the captured address.
  - Next state is always IDLE, so back-to-back requests each pay the full latency.
- **Error check**, evaluated on the captured address. The request is rejected if any of the following holds:
  - `addr[1:0]` is not 0;
  - `addr[31:2]` is at least `DEPTH`;
  - both `mem_read` and `mem_write` are high.
- A rejected request:
  - follows the same timing;
  - suppresses the write;
  - sets `rdata`=0 and pulses `addr_err` in DONE.
- Only the values captured in IDLE are used. Input changes during WAIT are ignored and are not flagged.
- `rdata` holds its last value outside DONE.
- Reset mid-operation (any state):
  - return to IDLE;
  - an uncommitted store is discarded;
  - outputs return to their reset values.

## Timing
- A request first seen in cycle t gives `stall` high in cycles t .. t+LATENCY-1.
- `done`, `rdata` valid and `stall`=0 occur in cycle t+LATENCY. The core advances on the edge ending t+LATENCY.
- A new request can be accepted in cycle t+LATENCY+1 (IDLE), so peak throughput is one access per LATENCY+1 cycles.
- `stall` is a combinational function of state and `req` only; there is no combinational path from `addr` or `wdata`.
- Store visibility: a load captured in any cycle after the store's DONE returns the new data.

## Structure
- The shared package `mips_pkg` holds the FSM state enum (IDLE/WAIT/DONE) and the `DATA_W`=32 constant.
- The counter width is $clog2(LATENCY)+1, computed locally.
- The single natural sub-module is `dmem_array`: DEPTH×32 storage with synchronous write and asynchronous read, indexed by `addr[$clog2(DEPTH)+1:2]`.

## Test plan
- Reset, then a store of 0xDEADBEEF to 0x10 with LATENCY=2 → `stall` high for 2 cycles, then `done`=1. A following load of 0x10 returns `rdata`=0xDEADBEEF in its DONE cycle.
- LATENCY=1, back-to-back loads of 0x0 and 0x4 → each has `stall` high 1 cycle; `done` pulses 2 cycles apart.
- Store to 0x13 (misaligned) and store to 0x400 with DEPTH=256 → `addr_err`=1 with `done`, and the array is unchanged when read back.
- `mem_read` and `mem_write` both high → `addr_err`=1, `rdata`=0, no write.
- Store issued, then `rst` asserted in WAIT → FSM returns to IDLE, `stall`=0, and a later load shows the old data.
- Change `addr` during WAIT → the result uses the captured address.
